// File: rtl/hilo_mult_ctrl_if.sv
// hilo_mult_ctrl_if
// Issue/result bundle between the execute stage and the HI/LO multiply
// controller.
//
// Signals:
//   issue_valid  execute stage presents a HI/LO-class instruction
//   issue_funct  R-type funct field of that instruction
//   rs_data      operand A, or the MTHI/MTLO source value
//   rt_data      operand B
//   issue_ready  controller is idle and will consume a recognised instruction
//   stall        execute must hold: recognised instruction presented while busy
//   busy         multiply in flight
//   mf_valid     mf_data carries the HI or LO value for an MFHI/MFLO this cycle
//   mf_data      HI or LO value, zero when no MFHI/MFLO is served
//   done         one-cycle pulse after a multiply commits HI/LO
//   hi_out       architectural HI register
//   lo_out       architectural LO register
//
// Handshake: an instruction is consumed on a cycle where issue_valid,
// issue_ready and a recognised funct coincide. A recognised instruction
// presented while issue_ready is low raises stall and has no side effect;
// the execute stage must keep issue_valid/issue_funct/rs_data/rt_data stable
// until the cycle stall drops. Unrecognised functs are ignored in any state.

interface hilo_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             issue_valid;
    logic [5:0]       issue_funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             issue_ready;
    logic             stall;
    logic             busy;
    logic             mf_valid;
    logic [WIDTH-1:0] mf_data;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output issue_valid, issue_funct, rs_data, rt_data,
        input  issue_ready, stall, busy, mf_valid, mf_data, done, hi_out, lo_out
    );

    modport slave (
        input  issue_valid, issue_funct, rs_data, rt_data,
        output issue_ready, stall, busy, mf_valid, mf_data, done, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl
// Multi-cycle MULT/MULTU sequencer and owner of the HI/LO registers.
// A multiply is accepted in IDLE, its 64-bit product is captured at
// acceptance, and HI/LO are committed MUL_LATENCY cycles later. Any
// recognised HI/LO instruction presented while the multiply is in flight
// stalls the pipeline and is serviced in the following IDLE cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (discards an in-flight multiply)
//   bus  hilo_mult_ctrl_if slave modport (issue side and HI/LO results)
//
// FSM state is visible externally: busy is high exactly in BUSY and
// issue_ready exactly in IDLE.

module hilo_mult_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int WIDTH       = 32
) (
    input logic             clk,
    input logic             rst,
    hilo_mult_ctrl_if.slave bus
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    localparam int CW = $clog2(MUL_LATENCY);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic is_mult, is_multu, is_mfhi, is_mflo, is_mthi, is_mtlo, recognised;
    logic [2*WIDTH-1:0] a_ext, b_ext;

    always_comb begin
        is_mult    = (bus.issue_funct == F_MULT);
        is_multu   = (bus.issue_funct == F_MULTU);
        is_mfhi    = (bus.issue_funct == F_MFHI);
        is_mflo    = (bus.issue_funct == F_MFLO);
        is_mthi    = (bus.issue_funct == F_MTHI);
        is_mtlo    = (bus.issue_funct == F_MTLO);
        recognised = is_mult | is_multu | is_mfhi | is_mflo | is_mthi | is_mtlo;
    end

    // The low 2*WIDTH bits of a product of sign-extended operands are the
    // exact signed product, so one unsigned multiplier serves both opcodes.
    always_comb begin
        a_ext  = is_mult ? {{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}
                         : {{WIDTH{1'b0}}, bus.rs_data};
        b_ext  = is_mult ? {{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data}
                         : {{WIDTH{1'b0}}, bus.rt_data};
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.issue_valid) begin
                        if (is_mult || is_multu) begin
                            prod_q  <= prod_d;
                            cnt_q   <= CW'(MUL_LATENCY - 1);
                            state_q <= BUSY;
                        end else if (is_mthi) begin
                            hi_q <= bus.rs_data;
                        end else if (is_mtlo) begin
                            lo_q <= bus.rs_data;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        hi_q    <= prod_q[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_q[WIDTH-1:0];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // MFHI/MFLO are answered combinationally, only while idle.
    logic mf_hit;
    assign mf_hit = bus.issue_valid & (state_q == IDLE) & (is_mfhi | is_mflo);

    assign bus.issue_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == BUSY);
    assign bus.stall       = bus.issue_valid & recognised & (state_q == BUSY);
    assign bus.mf_valid    = mf_hit;
    assign bus.mf_data     = mf_hit ? (is_mfhi ? hi_q : lo_q) : '0;
    assign bus.done        = done_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
Multi-cycle multiply sequencer and HI/LO register owner for the pipelined MIPS core. It accepts MULT/MULTU, MFHI/MFLO and MTHI/MTLO from the execute stage. It runs the 32x32->64 multiply over a fixed number of cycles, then commits HI/LO. While the multiply is in flight it drives a stall interlock back to the pipeline for any conflicting HI/LO access.

Parameters:
MUL_LATENCY, 4, cycles from multiply acceptance to HI/LO commit; legal range 2..16.
WIDTH, 32, operand and HI/LO width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
issue_valid  input  1  execute stage presents a HI/LO-class instruction this cycle
issue_funct  input  6  R-type funct: MULT 011000, MULTU 011001, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
rs_data  input  WIDTH  operand A, or the MTHI/MTLO source
rt_data  input  WIDTH  operand B
issue_ready  output  1  controller can accept an instruction this cycle (state IDLE)
stall  output  1  pipeline must hold execute; equals issue_valid & recognised funct & busy
busy  output  1  multiply in flight
mf_valid  output  1  mf_data is valid this cycle
mf_data  output  WIDTH  HI or LO value for MFHI/MFLO
done  output  1  one-cycle pulse: HI/LO were just committed by a multiply
hi_out  output  WIDTH  current HI (debug/visibility)
lo_out  output  WIDTH  current LO (debug/visibility)

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, HI=LO=0, counter=0, product register=0, done=0. All outputs are therefore 0 except issue_ready=1. rst overrides everything, including an in-flight multiply, which is discarded with no HI/LO write.
- States: IDLE, BUSY.
- IDLE, issue_valid with MULT/MULTU:
  - Latch the 64-bit product into the product register. MULT is signed*signed; MULTU is unsigned*unsigned.
  - counter <= MUL_LATENCY-1; next state BUSY. The instruction is accepted and stall=0 this cycle.
- IDLE, MFHI/MFLO: combinational, same cycle. mf_valid=1; mf_data=HI for MFHI, LO for MFLO. No state change.
- IDLE, MTHI/MTLO: HI or LO <= rs_data at the next edge; the other register is unchanged; mf_valid=0.
- mf_valid=0 and mf_data=0 whenever no MFHI/MFLO is being served.
- Unrecognised funct or issue_valid=0: no effect, stall=0.
- BUSY: busy=1, issue_ready=0.
  - Each cycle: counter decrements.
  - When counter==0: HI<=product[63:32], LO<=product[31:0]; next state IDLE; done<=1 (registered, high for exactly the first IDLE cycle).
- BUSY, any recognised funct presented: stall=1, instruction not consumed, no HI/LO side effect. This holds even in the commit cycle.
  - The held instruction is serviced in the following IDLE cycle: an MFHI then sees the new product, and an MT* then overwrites it.
- Timing: multiply accepted at edge E0. busy=1 for exactly MUL_LATENCY cycles. HI/LO show the new value from edge E0+MUL_LATENCY. done=1 in the cycle after that edge. A new multiply may be accepted in that same done cycle (back-to-back, zero bubble).
- Operands are sampled only at acceptance. rs_data/rt_data changes during BUSY do not affect the result.
- Product is full 64-bit, so there is no overflow or trap. Signed MULT sign-extends both operands to 64 bits before multiplying.
- hi_out/lo_out always reflect the architectural HI/LO registers.

Test Plan:
- Reset then MFHI/MFLO in IDLE -> mf_valid=1, mf_data=0x00000000 for both; issue_ready=1, busy=0.
- MULTU rs=0xFFFFFFFF rt=0x00000002, MUL_LATENCY=4 -> busy high 4 cycles; then HI=0x00000001, LO=0xFFFFFFFE; done pulses one cycle.
- MULT rs=0xFFFFFFFF (-1) rt=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
- MULT 3*5 accepted, MFLO held on issue_valid next cycle -> stall=1 for 4 cycles, mf_valid=0. In the IDLE cycle: stall=0, mf_valid=1, mf_data=0x0000000F. Changing rs/rt mid-BUSY does not alter the result.
- MTHI rs=0xDEADBEEF then MTLO rs=0x12345678 in IDLE -> hi_out=0xDEADBEEF, lo_out=0x12345678. MULT issued in the done cycle of a prior multiply is accepted immediately (issue_ready=1).
- MULTU 7*9 accepted, rst=1 asserted on the 2nd BUSY cycle -> next cycle IDLE, busy=0, HI=LO=0, no done pulse.
